// File: rtl/cruise_speed_regulator.sv
// Cruise-control regulator: owns the target speed fed to the speed
// comparator, debounces its G/Eq/L result and drives accel/decel.
module cruise_speed_regulator #(
    parameter int SPEED_W     = 8,
    parameter int MIN_SPEED   = 40,
    parameter int MAX_SPEED   = 200,
    parameter int STEP        = 2,
    parameter int HOLD_CYCLES = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cruise_en,
    input  logic               brake,
    input  logic               set,
    input  logic               resume,
    input  logic               inc,
    input  logic               dec,
    input  logic [SPEED_W-1:0] cur_speed,
    input  logic               G,
    input  logic               Eq,
    input  logic               L,
    output logic [SPEED_W-1:0] target_speed,
    output logic               active,
    output logic               accel,
    output logic               decel,
    output logic               cmp_err
);

    localparam int CNT_W = $clog2(HOLD_CYCLES + 1);

    localparam logic [SPEED_W:0] STEP_X = (SPEED_W+1)'(STEP);
    localparam logic [SPEED_W:0] MIN_X  = (SPEED_W+1)'(MIN_SPEED);
    localparam logic [SPEED_W:0] MAX_X  = (SPEED_W+1)'(MAX_SPEED);
    localparam logic [SPEED_W:0] FLOOR  = MIN_X + STEP_X;

    localparam logic [CNT_W-1:0] HOLD = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    localparam logic [1:0] CODE_NONE = 2'd0;
    localparam logic [1:0] CODE_L    = 2'd1;
    localparam logic [1:0] CODE_EQ   = 2'd2;
    localparam logic [1:0] CODE_G    = 2'd3;

    typedef enum logic [1:0] {
        OFF,
        STANDBY,
        CRUISE
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [SPEED_W-1:0] target_q;
    logic [SPEED_W-1:0] target_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic [1:0]         last_q;
    logic [1:0]         last_d;
    logic               accel_q;
    logic               accel_d;
    logic               decel_q;
    logic               decel_d;
    logic               err_q;
    logic               err_d;

    logic [SPEED_W:0]   cur_x;
    logic [SPEED_W:0]   tgt_x;
    logic [SPEED_W:0]   inc_sum;
    logic [SPEED_W:0]   dec_diff;
    logic [SPEED_W-1:0] inc_val;
    logic [SPEED_W-1:0] dec_val;
    logic               in_range;
    logic               cmp_legal;
    logic [1:0]         code_now;
    logic               same_code;
    logic [CNT_W-1:0]   cnt_inc;

    // Saturating target arithmetic, one bit wider so nothing wraps.
    always_comb begin
        cur_x    = {1'b0, cur_speed};
        tgt_x    = {1'b0, target_q};
        inc_sum  = tgt_x + STEP_X;
        dec_diff = tgt_x - STEP_X;
        inc_val  = (inc_sum > MAX_X) ? MAX_X[SPEED_W-1:0]
                                     : inc_sum[SPEED_W-1:0];
        dec_val  = (tgt_x < FLOOR) ? MIN_X[SPEED_W-1:0]
                                   : dec_diff[SPEED_W-1:0];
        in_range = (cur_x >= MIN_X) && (cur_x <= MAX_X);
    end

    // Comparator result decode; exactly one of G/Eq/L must be high.
    always_comb begin
        cmp_legal = (G ^ Eq ^ L) && !(G && Eq && L);
        code_now  = CODE_NONE;
        if (G) begin
            code_now = CODE_G;
        end else if (Eq) begin
            code_now = CODE_EQ;
        end else if (L) begin
            code_now = CODE_L;
        end
        same_code = (code_now == last_q) && (cnt_q != '0);
        cnt_inc   = (cnt_q >= HOLD) ? HOLD : cnt_q + ONE;
    end

    // Next state, target, debounce counter and command outputs.
    always_comb begin
        logic debounce;
        state_d  = state_q;
        target_d = target_q;
        cnt_d    = '0;
        last_d   = last_q;
        accel_d  = 1'b0;
        decel_d  = 1'b0;
        err_d    = 1'b0;
        debounce = 1'b0;

        if (!cruise_en) begin
            state_d  = OFF;
            target_d = '0;
        end else begin
            case (state_q)
                OFF: begin
                    state_d = STANDBY;
                end
                STANDBY: begin
                    if (!brake) begin
                        if (set) begin
                            if (in_range) begin
                                state_d  = CRUISE;
                                target_d = cur_speed;
                            end
                        end else if (resume && target_q != '0) begin
                            state_d = CRUISE;
                        end
                    end
                end
                CRUISE: begin
                    if (brake) begin
                        state_d = STANDBY;
                    end else if (set && in_range) begin
                        target_d = cur_speed;
                    end else if (!set && !resume && (inc ^ dec)) begin
                        target_d = inc ? inc_val : dec_val;
                    end else begin
                        debounce = 1'b1;
                    end
                end
                default: begin
                    state_d  = OFF;
                    target_d = '0;
                end
            endcase
        end

        if (debounce) begin
            if (!cmp_legal) begin
                err_d = 1'b1;
            end else begin
                last_d  = code_now;
                cnt_d   = same_code ? cnt_inc : ONE;
                accel_d = (code_now == CODE_L) && (cnt_d == HOLD);
                decel_d = (code_now == CODE_G) && (cnt_d == HOLD);
            end
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= OFF;
            target_q <= '0;
            cnt_q    <= '0;
            last_q   <= CODE_NONE;
            accel_q  <= 1'b0;
            decel_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
            accel_q  <= accel_d;
            decel_q  <= decel_d;
            err_q    <= err_d;
        end
    end

    assign target_speed = target_q;
    assign active       = (state_q == CRUISE);
    assign accel        = accel_q;
    assign decel        = decel_q;
    assign cmp_err      = err_q;

endmodule

// File: tb/tb_cruise_speed_regulator.sv
// Scoreboard bench for cruise_speed_regulator: directed scenarios
// followed by randomized traffic against a behavioural model.
module tb_cruise_speed_regulator;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       cruise_en = 1'b0;
    logic       brake = 1'b0;
    logic       set = 1'b0;
    logic       resume = 1'b0;
    logic       inc = 1'b0;
    logic       dec = 1'b0;
    logic [7:0] cur_speed = 8'd0;
    logic       G = 1'b0;
    logic       Eq = 1'b0;
    logic       L = 1'b0;
    logic [7:0] target_speed;
    logic       active;
    logic       accel;
    logic       decel;
    logic       cmp_err;

    cruise_speed_regulator dut (
        .clk          (clk),
        .reset        (reset),
        .cruise_en    (cruise_en),
        .brake        (brake),
        .set          (set),
        .resume       (resume),
        .inc          (inc),
        .dec          (dec),
        .cur_speed    (cur_speed),
        .G            (G),
        .Eq           (Eq),
        .L            (L),
        .target_speed (target_speed),
        .active       (active),
        .accel        (accel),
        .decel        (decel),
        .cmp_err      (cmp_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] tgt;
        logic       act;
        logic       acc;
        logic       dcl;
        logic       err;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    tests = 0;
    int    failed = 0;
    string phase = "reset";

    // Behavioural model: mode 0=off, 1=standby, 2=cruise.
    int m_mode = 0;
    int m_tgt = 0;
    int m_last = 0;
    int m_run = 0;
    bit m_acc = 0;
    bit m_dcl = 0;
    bit m_err = 0;

    int illegal_pat[5] = '{0, 3, 5, 6, 7};

    // Apply one cycle of inputs; code -1 = real comparator, -2 = random
    // illegal code, 0..7 = raw {G,Eq,L} pattern.
    task automatic drive(input bit rst, input bit en, input bit brk,
                         input bit st, input bit rs, input bit ic,
                         input bit dc, input int spd, input int code);
        int   pat;
        bit   deb;
        bit   ok;
        exp_t e;
        @(negedge clk);
        if (code == -1) begin
            pat = (spd < m_tgt) ? 1 : (spd == m_tgt) ? 2 : 4;
        end else if (code == -2) begin
            pat = illegal_pat[$urandom_range(4)];
        end else begin
            pat = code;
        end
        reset     = rst;
        cruise_en = en;
        brake     = brk;
        set       = st;
        resume    = rs;
        inc       = ic;
        dec       = dc;
        cur_speed = 8'(spd);
        G         = pat[2];
        Eq        = pat[1];
        L         = pat[0];

        ok    = (spd >= 40) && (spd <= 200);
        deb   = 0;
        m_acc = 0;
        m_dcl = 0;
        m_err = 0;
        if (rst || !en) begin
            m_mode = 0;
            m_tgt  = 0;
            m_run  = 0;
        end else if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 1) begin
            if (!brk) begin
                if (st) begin
                    if (ok) begin
                        m_mode = 2;
                        m_tgt  = spd;
                    end
                end else if (rs && m_tgt != 0) begin
                    m_mode = 2;
                end
            end
        end else begin
            if (brk) begin
                m_mode = 1;
                m_run  = 0;
            end else if (st && ok) begin
                m_tgt = spd;
                m_run = 0;
            end else if (!st && !rs && ic != dc) begin
                if (ic) m_tgt = (m_tgt + 2 > 200) ? 200 : m_tgt + 2;
                else    m_tgt = (m_tgt - 2 < 40) ? 40 : m_tgt - 2;
                m_run = 0;
            end else begin
                deb = 1;
            end
        end
        if (deb) begin
            if (pat != 1 && pat != 2 && pat != 4) begin
                m_err = 1;
                m_run = 0;
            end else begin
                if (m_run > 0 && pat == m_last)
                    m_run = (m_run >= 4) ? 4 : m_run + 1;
                else
                    m_run = 1;
                m_last = pat;
                m_acc  = (pat == 1) && (m_run == 4);
                m_dcl  = (pat == 4) && (m_run == 4);
            end
        end
        e.tgt = 8'(m_tgt);
        e.act = (m_mode == 2);
        e.acc = m_acc;
        e.dcl = m_dcl;
        e.err = m_err;
        exp_q.push_back(e);
        name_q.push_back(phase);
    endtask

    task automatic idle(input int spd, input int n);
        for (int i = 0; i < n; i++) drive(0, 1, 0, 0, 0, 0, 0, spd, -1);
    endtask

    // Monitor: the DUT presents outputs every cycle; compare after each edge.
    initial begin
        exp_t  e;
        exp_t  got;
        string nm;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                nm  = name_q.pop_front();
                got = {target_speed, active, accel, decel, cmp_err};
                tests++;
                if (got !== e) begin
                    failed++;
                    $display("FAIL %s: got tgt=%0d act=%b acc=%b dec=%b err=%b, expected tgt=%0d act=%b acc=%b dec=%b err=%b",
                             nm, got.tgt, got.act, got.acc, got.dcl, got.err,
                             e.tgt, e.act, e.acc, e.dcl, e.err);
                end
            end
        end
    end

    initial begin
        int spd;
        bit rst, en, brk, st, rs, ic, dc;
        int code;

        phase = "T1_reset";
        drive(1, 0, 0, 0, 0, 0, 0, 0, -1);
        phase = "T1_set";
        drive(0, 1, 0, 0, 0, 0, 0, 100, -1);
        drive(0, 1, 0, 1, 0, 0, 0, 100, -1);
        phase = "T1_eq";
        idle(100, 2);

        phase = "T2_accel";
        idle(95, 5);
        phase = "T2_release";
        idle(100, 2);

        phase = "T3_mixed";
        idle(95, 3);
        phase = "T3_decel";
        idle(105, 6);

        phase = "T4_inc_max";
        drive(0, 1, 0, 1, 0, 0, 0, 198, -1);
        drive(0, 1, 0, 0, 0, 1, 0, 198, -1);
        drive(0, 1, 0, 0, 0, 1, 0, 198, -1);
        phase = "T4_dec_min";
        drive(0, 1, 0, 1, 0, 0, 0, 40, -1);
        drive(0, 1, 0, 0, 0, 0, 1, 40, -1);
        phase = "T4_inc_dec";
        drive(0, 1, 0, 0, 0, 1, 1, 40, -1);

        phase = "T5_brake";
        drive(0, 1, 0, 1, 0, 0, 0, 100, -1);
        idle(95, 4);
        drive(0, 1, 1, 0, 0, 0, 0, 95, -1);
        idle(95, 1);
        phase = "T5_resume";
        drive(0, 1, 0, 0, 1, 0, 0, 100, -1);
        phase = "T5_off";
        drive(0, 0, 0, 0, 0, 0, 0, 100, -1);
        drive(0, 1, 0, 0, 0, 0, 0, 30, -1);
        phase = "T5_set_low";
        drive(0, 1, 0, 1, 0, 0, 0, 30, -1);
        drive(0, 1, 0, 1, 0, 0, 0, 201, -1);

        phase = "T6_cmp_err";
        drive(0, 1, 0, 1, 0, 0, 0, 100, -1);
        idle(95, 4);
        drive(0, 1, 0, 0, 0, 0, 0, 95, 6);
        idle(95, 4);
        phase = "T6_reset";
        drive(1, 1, 0, 0, 0, 0, 0, 95, -1);
        drive(0, 1, 0, 0, 0, 0, 0, 95, -1);

        phase = "random";
        spd = 100;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(9) == 0) begin
                if ($urandom_range(1) == 0)
                    spd = $urandom_range(255);
                else if (m_tgt >= 3)
                    spd = m_tgt - 3 + $urandom_range(6);
            end
            rst  = ($urandom_range(499) == 0);
            en   = ($urandom_range(59) != 0);
            brk  = ($urandom_range(39) == 0);
            st   = ($urandom_range(24) == 0);
            rs   = ($urandom_range(24) == 0);
            ic   = ($urandom_range(9) == 0);
            dc   = ($urandom_range(9) == 0);
            code = ($urandom_range(29) == 0) ? -2 : -1;
            drive(rst, en, brk, st, rs, ic, dc, spd, code);
        end

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
        if (exp_q.size() != 0) begin
            failed++;
            $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
